prog_run_ctrl: RTL
==================

Name: prog_run_ctrl

Overview:
- Host-side initiator for the core's start/halt interface.
- Streams a program into instruction memory and holds core start high for a fixed number of cycles, then releases it.
- Waits for the core to raise halt, counting cycles, and aborts on timeout.
- Sits between the bench/host loader and the top-level core; the core is the responder on start/halt.

Parameters:
- INSTR_WIDTH, 9, instruction word width.
- ADDR_WIDTH, 8, instruction memory address width.
- START_CYCLES, 4, cycles core_start is held high before release (min 1).
- CNT_WIDTH, 32, width of cycle counter.
- TIMEOUT, 100000, run cycles before abort (must be < 2^CNT_WIDTH).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- go  in  1  one-cycle request to load and run a program; ignored unless state is IDLE or DONE.
- prog_len  in  ADDR_WIDTH+1  number of words to load, sampled on go; 0 means skip load.
- ld_valid  in  1  loader word valid.
- ld_data  in  INSTR_WIDTH  loader word.
- ld_ready  out  1  high only in LOAD.
- im_we  out  1  instruction memory write enable.
- im_addr  out  ADDR_WIDTH  instruction memory write address.
- im_wdata  out  INSTR_WIDTH  instruction memory write data.
- core_start  out  1  start to core.
- core_halt  in  1  halt from core.
- busy  out  1  high in LOAD, START and RUN.
- done  out  1  high in DONE.
- timed_out  out  1  valid with done; run ended by timeout.
- cycle_count  out  CNT_WIDTH  cycles from start release to halt, frozen in DONE.

Behaviour:
- Reset (async, rst_n=0), all outputs 0:
  - state=IDLE; ld_ready, im_we, im_addr, im_wdata, core_start, busy, done, timed_out, cycle_count all 0.
  - Asserting rst_n low in any state aborts immediately, including mid-load or mid-run.
- States: IDLE, LOAD, START, RUN, DONE.
- IDLE/DONE + go:
  - Latch prog_len; clear load index, cycle_count and timed_out; done drops the next cycle.
  - If prog_len==0, go to START; else go to LOAD.
- LOAD:
  - ld_ready=1. On each cycle with ld_valid&ld_ready, im_we=1, im_addr=index and im_wdata=ld_data are registered outputs, valid the following cycle. Then index++.
  - After the prog_len-th accepted word, go to START; ld_ready drops in the same edge.
  - ld_valid=0 leaves the state stalled indefinitely, with no timeout in LOAD.
  - prog_len=2^ADDR_WIDTH fills memory; the index does not wrap before exit.
- START:
  - Entered on the cycle after the final im_we pulse completes, so no overlap between im_we and core_start.
  - core_start=1 for exactly START_CYCLES cycles, counted by an internal counter, then go to RUN with core_start=0.
  - core_halt is ignored in START, because the core may hold halt from a previous run while in reset.
- RUN:
  - core_start=0. cycle_count increments by 1 each cycle, starting at 1 on the first RUN cycle.
  - core_halt=1 → DONE with timed_out=0; cycle_count excludes the halt-detect cycle, so halt seen on the first RUN cycle gives count 0.
  - cycle_count reaching TIMEOUT with no halt → DONE with timed_out=1 and cycle_count=TIMEOUT.
  - If halt and the timeout condition occur in the same cycle, halt wins (timed_out=0).
- DONE: done=1, outputs held; go restarts the sequence as from IDLE.
- Any go outside IDLE/DONE is dropped, with no queuing.
- cycle_count saturates; it never wraps.

Test Plan:
- Reset mid-RUN: assert rst_n=0 asynchronously, between clock edges → core_start, busy, done, cycle_count go to 0 without a clock edge; state=IDLE after release.
- Load 3 words 0x1A5, 0x0FF, 0x100 with ld_valid gaps of 2 cycles:
  - Expect im_we pulses at addr 0, 1, 2 with matching data.
  - Then core_start high exactly 4 cycles; busy high throughout.
- prog_len=0, go → no ld_ready or im_we; core_start high 4 cycles the cycle after go; core model raises halt 10 cycles after release → done=1, cycle_count=10, timed_out=0.
- TIMEOUT=50 override, core never halts → done=1, timed_out=1, cycle_count=50; core_start stays 0.
- core_halt held 1 during START, deasserted at release, reasserted 7 cycles later → ignored in START; cycle_count=7.
- go pulsed during LOAD, then go in DONE → first ignored; second restarts: done drops, cycle_count clears, new load begins at addr 0.

Source files
------------

// File: rtl/prog_run_ctrl.sv
// Host-side program loader and run controller: streams a program into instruction
// memory, pulses core_start for a fixed window, then times the core until halt.
module prog_run_ctrl #(
    parameter int INSTR_WIDTH  = 9,
    parameter int ADDR_WIDTH   = 8,
    parameter int START_CYCLES = 4,
    parameter int CNT_WIDTH    = 32,
    parameter int TIMEOUT      = 100000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   go,
    input  logic [ADDR_WIDTH:0]    prog_len,
    input  logic                   ld_valid,
    input  logic [INSTR_WIDTH-1:0] ld_data,
    output logic                   ld_ready,
    output logic                   im_we,
    output logic [ADDR_WIDTH-1:0]  im_addr,
    output logic [INSTR_WIDTH-1:0] im_wdata,
    output logic                   core_start,
    input  logic                   core_halt,
    output logic                   busy,
    output logic                   done,
    output logic                   timed_out,
    output logic [CNT_WIDTH-1:0]   cycle_count,
    output logic [2:0]             state
);

    // Loader handshake: a word transfers on any rising edge where ld_valid && ld_ready.
    // ld_ready is high only while LOAD still expects words.

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] START = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int SC_W = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SC_W-1:0]      START_LAST = SC_W'(START_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TO_LAST    = CNT_WIDTH'(TIMEOUT - 1);
    localparam logic [ADDR_WIDTH:0]  IDX_ONE    = (ADDR_WIDTH + 1)'(1);

    logic [ADDR_WIDTH:0] len_q;
    logic [ADDR_WIDTH:0] idx;
    logic [ADDR_WIDTH:0] idx_next;
    logic [SC_W-1:0]     start_cnt;
    logic                load_last;
    logic [CNT_WIDTH-1:0] count_inc;

    assign idx_next  = idx + IDX_ONE;
    assign count_inc = (cycle_count != '1) ? cycle_count + 1'b1 : cycle_count;

    assign ld_ready   = (state == LOAD) && !load_last;
    assign core_start = (state == START);
    assign busy       = (state == LOAD) || (state == START) || (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            len_q       <= '0;
            idx         <= '0;
            start_cnt   <= '0;
            load_last   <= 1'b0;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            timed_out   <= 1'b0;
            cycle_count <= '0;
        end else begin
            im_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        len_q       <= prog_len;
                        idx         <= '0;
                        start_cnt   <= '0;
                        load_last   <= 1'b0;
                        cycle_count <= '0;
                        timed_out   <= 1'b0;
                        state       <= (prog_len == '0) ? START : LOAD;
                    end
                end
                LOAD: begin
                    // Linger one cycle after the final word so the last write
                    // pulse never overlaps core_start.
                    if (load_last) begin
                        state <= START;
                    end else if (ld_valid) begin
                        im_we    <= 1'b1;
                        im_addr  <= idx[ADDR_WIDTH-1:0];
                        im_wdata <= ld_data;
                        idx      <= idx_next;
                        if (idx_next == len_q) load_last <= 1'b1;
                    end
                end
                START: begin
                    if (start_cnt == START_LAST) state <= RUN;
                    else start_cnt <= start_cnt + 1'b1;
                end
                RUN: begin
                    if (core_halt) begin
                        state <= DONE;
                    end else begin
                        cycle_count <= count_inc;
                        if (cycle_count == TO_LAST) begin
                            timed_out <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
